// File: rtl/spi_slave_mmio_if.sv
// Bus and SPI pin bundle for spi_slave_mmio: word-addressed register access plus the external SPI wires.
interface spi_slave_mmio_if;
  logic        addr;
  logic        we;
  logic        re;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        sck;
  logic        ss;
  logic        mosi;
  logic        miso;

  modport slave (
    input  addr, we, re, wd, sck, ss, mosi,
    output rd, miso
  );

  modport master (
    output addr, we, re, wd, sck, ss, mosi,
    input  rd, miso
  );
endinterface

// File: rtl/spi_slave_mmio.sv
// Memory-mapped SPI slave (mode 0, MSB first) with RX FIFO and one-byte TX holding register.
// Optional interrupt output enabled by defining SPI_SLAVE_MMIO_IRQ_EN.
module spi_slave_mmio #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_TX     = 8'hff
) (
  input  logic            clk,
  input  logic            rst,
  spi_slave_mmio_if.slave bus
`ifdef SPI_SLAVE_MMIO_IRQ_EN
  ,
  output logic            irq
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
  logic                   sck_prev, ss_prev;
  logic                   sck_s, ss_s, mosi_s;
  logic                   sck_rise, sck_fall, ss_rise, ss_fall;

  logic [7:0]             rx_sh, tx_sh, tx_reg, push_data;
  logic [2:0]             bit_cnt;
  logic                   tx_pend, reload, push_pend, ovf;

  logic [7:0]             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;

  logic                   load_tx_c, rise_c, fall_c, end_c, last_c, take_tx_c;
  logic [7:0]             tx_next_c;
  logic                   pop_c, full_c, push_ok_c, rx_valid_c;
  logic [31:0]            status_c;
  logic                   unused_wd_c;

  assign unused_wd_c = ^bus.wd[31:8];

  // Synchronisers; ss resets low so a frame already in progress at reset is never picked up mid-byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
      ss_prev   <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.ss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sck_prev  <= sck_s;
      ss_prev   <= ss_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign ss_s     = ss_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign ss_rise  = ss_s & ~ss_prev;
  assign ss_fall  = ~ss_s & ss_prev;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_tx_c = 1'b0;
    rise_c    = 1'b0;
    fall_c    = 1'b0;
    end_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ss_fall) begin
          state_nxt = ST_ACTIVE;
          load_tx_c = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (ss_rise) begin
          state_nxt = ST_IDLE;
          end_c     = 1'b1;
        end else begin
          rise_c = sck_rise;
          fall_c = sck_fall;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign last_c    = rise_c && (bit_cnt == 3'd7);
  assign take_tx_c = load_tx_c | last_c;
  assign tx_next_c = tx_pend ? tx_reg : IDLE_TX;

  // Shift datapath; after a byte boundary the reloaded tx byte appears on the next fall without shifting.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sh     <= '0;
      tx_sh     <= '0;
      bit_cnt   <= '0;
      reload    <= 1'b0;
      push_pend <= 1'b0;
      push_data <= '0;
      bus.miso  <= IDLE_TX[7];
    end else begin
      push_pend <= 1'b0;
      if (end_c) begin
        rx_sh    <= '0;
        bit_cnt  <= '0;
        reload   <= 1'b0;
        bus.miso <= IDLE_TX[7];
      end else if (load_tx_c) begin
        tx_sh    <= tx_next_c;
        bit_cnt  <= '0;
        reload   <= 1'b0;
        bus.miso <= tx_next_c[7];
      end else if (rise_c) begin
        rx_sh <= {rx_sh[6:0], mosi_s};
        if (last_c) begin
          push_pend <= 1'b1;
          push_data <= {rx_sh[6:0], mosi_s};
          bit_cnt   <= '0;
          tx_sh     <= tx_next_c;
          reload    <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else if (fall_c) begin
        if (reload) begin
          bus.miso <= tx_sh[7];
          reload   <= 1'b0;
        end else begin
          tx_sh    <= {tx_sh[6:0], 1'b0};
          bus.miso <= tx_sh[6];
        end
      end
    end
  end

  // TX holding register: a bus write issued on the same clk as a take wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_reg  <= '0;
      tx_pend <= 1'b0;
    end else begin
      if (take_tx_c) tx_pend <= 1'b0;
      if (bus.we && !bus.addr) begin
        tx_reg  <= bus.wd[7:0];
        tx_pend <= 1'b1;
      end
    end
  end

  assign rx_valid_c = (count != '0);
  assign full_c     = (count == CNT_W'(FIFO_DEPTH));
  assign pop_c      = bus.re && !bus.addr && rx_valid_c;
  assign push_ok_c  = push_pend && (!full_c || pop_c);

  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= push_data;
  end

  // FIFO pointers, occupancy and sticky overflow; a new overflow beats a same-clk clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok_c && !pop_c)      count <= count + CNT_W'(1);
      else if (!push_ok_c && pop_c) count <= count - CNT_W'(1);
      if (push_pend && !push_ok_c)                ovf <= 1'b1;
      else if (bus.we && bus.addr && bus.wd[3])   ovf <= 1'b0;
    end
  end

`ifdef SPI_SLAVE_MMIO_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (bus.we && bus.addr) irq_en <= bus.wd[4];
      irq <= irq_en & (rx_valid_c | ovf);
    end
  end
`endif

  always_comb begin
    status_c       = '0;
    status_c[0]    = rx_valid_c;
    status_c[1]    = (state == ST_ACTIVE);
    status_c[2]    = tx_pend;
    status_c[3]    = ovf;
`ifdef SPI_SLAVE_MMIO_IRQ_EN
    status_c[4]    = irq_en;
`endif
    status_c[11:8] = 4'(count);
  end

  always_comb begin
    bus.rd = '0;
    if (bus.addr)        bus.rd = status_c;
    else if (rx_valid_c) bus.rd = {24'b0, mem[rd_ptr]};
  end

endmodule

// File: tb/tb_spi_slave_mmio.sv
// Self-checking bench for spi_slave_mmio: bit-banged SPI master, bus tasks, RX scoreboard.
module tb_spi_slave_mmio;

  localparam int unsigned HALF = 8;

`ifdef SPI_SLAVE_MMIO_IRQ_EN
  localparam logic [31:0] IRQ_ST = 32'h10;
  logic irq;
`else
  localparam logic [31:0] IRQ_ST = 32'h0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] sb[$];

  spi_slave_mmio_if bus_if();

  spi_slave_mmio #(
    .FIFO_DEPTH (8),
    .SYNC_STAGES(2),
    .IDLE_TX    (8'hff)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
`ifdef SPI_SLAVE_MMIO_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        do_wr;
    logic [7:0]  wr;
    logic [7:0]  mosi;
    logic [7:0]  miso_exp;
    logic [31:0] st_exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic a, input logic [31:0] d);
    @(negedge clk);
    bus_if.addr = a;
    bus_if.wd   = d;
    bus_if.we   = 1'b1;
    @(negedge clk);
    bus_if.we   = 1'b0;
  endtask

  task automatic bus_read(input logic a, output logic [31:0] d);
    @(negedge clk);
    bus_if.addr = a;
    bus_if.re   = 1'b1;
    #1 d = bus_if.rd;
    @(negedge clk);
    bus_if.re   = 1'b0;
  endtask

  task automatic status_check(input string name, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(1'b1, d);
    check(name, d, exp);
  endtask

  task automatic drain(input int n);
    logic [31:0] d;
    logic [7:0]  e;
    for (int k = 0; k < n; k++) begin
      bus_read(1'b0, d);
      e = (sb.size() != 0) ? sb.pop_front() : 8'h00;
      check("data_pop", d, {24'b0, e});
    end
  endtask

  task automatic ss_low();
    bus_if.ss = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic ss_high();
    repeat (HALF) @(negedge clk);
    bus_if.ss = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  // Sends the top n bits of tx, MSB first; rx collects miso sampled just before each rise.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int k = 0; k < n; k++) begin
      bus_if.mosi = tx[3'(7 - k)];
      repeat (HALF) @(negedge clk);
      rx[3'(7 - k)] = bus_if.miso;
      bus_if.sck = 1'b1;
      repeat (HALF) @(negedge clk);
      bus_if.sck = 1'b0;
    end
  endtask

  task automatic frame1(input logic [7:0] tx, output logic [7:0] rx);
    ss_low();
    spi_bits(tx, 8, rx);
    ss_high();
  endtask

  vec_t        vecs[4];
  logic [7:0]  rx;
  logic [31:0] d;

  initial begin
    vecs[0] = '{1'b0, 8'h00, 8'haa, 8'hff, 32'h101};
    vecs[1] = '{1'b1, 8'h5c, 8'h00, 8'h5c, 32'h101};
    vecs[2] = '{1'b1, 8'ha5, 8'h3c, 8'ha5, 32'h101};
    vecs[3] = '{1'b0, 8'h00, 8'h81, 8'hff, 32'h101};

    rst         = 1'b1;
    bus_if.addr = 1'b0;
    bus_if.we   = 1'b0;
    bus_if.re   = 1'b0;
    bus_if.wd   = '0;
    bus_if.sck  = 1'b0;
    bus_if.ss   = 1'b1;
    bus_if.mosi = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    #1 check("reset_miso", 32'(bus_if.miso), 32'h1);
`ifdef SPI_SLAVE_MMIO_IRQ_EN
    check("reset_irq", 32'(irq), 32'h0);
`endif
    status_check("reset_status", 32'h0);
    drain(1);

    // Single-byte frames from the vector table
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].do_wr) bus_write(1'b0, {24'b0, vecs[i].wr});
      frame1(vecs[i].mosi, rx);
      sb.push_back(vecs[i].mosi);
      check("vec_miso", {24'b0, rx}, {24'b0, vecs[i].miso_exp});
      status_check("vec_status", vecs[i].st_exp);
      drain(1);
      status_check("vec_status_empty", 32'h0);
    end

    // TX byte consumed at ss fall; second byte in the frame gets the idle byte
    bus_write(1'b0, 32'h5c);
    status_check("txpend_set", 32'h4);
    ss_low();
    status_check("txpend_cleared_busy", 32'h2);
    spi_bits(8'h00, 8, rx);
    check("two_byte_first_miso", {24'b0, rx}, 32'h5c);
    spi_bits(8'h00, 8, rx);
    check("two_byte_second_miso", {24'b0, rx}, 32'hff);
    ss_high();
    sb.push_back(8'h00);
    sb.push_back(8'h00);
    status_check("two_byte_status", 32'h201);
    drain(2);

    // Overflow: ninth byte dropped, sticky ovf cleared by STATUS write
    begin
      logic [7:0] ob [9];
      ob = '{8'hde, 8'had, 8'hbe, 8'hef, 8'hc0, 8'h01, 8'hc0, 8'hde, 8'h12};
      ss_low();
      for (int i = 0; i < 9; i++) begin
        spi_bits(ob[i], 8, rx);
        if (i < 8) sb.push_back(ob[i]);
      end
      ss_high();
    end
    status_check("ovf_status", 32'h809);
    bus_write(1'b1, 32'h8);
    status_check("ovf_cleared", 32'h801);
    drain(8);
    status_check("ovf_drained", 32'h0);

    // Frame aborted after 5 bits: nothing pushed, next byte intact
    ss_low();
    spi_bits(8'hff, 5, rx);
    ss_high();
    status_check("partial_status", 32'h0);
    frame1(8'h3c, rx);
    sb.push_back(8'h3c);
    status_check("after_partial_status", 32'h101);
    drain(1);

    // FIFO full with a DATA read on the same clk as the 8th-bit push
    ss_low();
    for (int i = 0; i < 8; i++) begin
      spi_bits(8'(8'h10 + i), 8, rx);
      sb.push_back(8'(8'h10 + i));
    end
    spi_bits(8'h99, 7, rx);
    bus_if.mosi = 1'b1;
    repeat (HALF) @(negedge clk);
    bus_if.sck = 1'b1;
    repeat (3) @(negedge clk);
    bus_if.addr = 1'b0;
    bus_if.re   = 1'b1;
    #1 d = bus_if.rd;
    @(negedge clk);
    bus_if.re = 1'b0;
    check("full_pop_head", d, {24'b0, sb.pop_front()});
    sb.push_back(8'h99);
    repeat (HALF - 4) @(negedge clk);
    bus_if.sck = 1'b0;
    ss_high();
    status_check("full_pushpop_status", 32'h801);
    drain(8);
    status_check("full_drained", 32'h0);

    // Reset in the middle of a byte
    frame1(8'h55, rx);
    ss_low();
    bus_write(1'b0, 32'h42);
    spi_bits(8'hf0, 4, rx);
    status_check("pre_reset_status", 32'h107);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 check("midreset_miso", 32'(bus_if.miso), 32'h1);
`ifdef SPI_SLAVE_MMIO_IRQ_EN
    check("midreset_irq", 32'(irq), 32'h0);
`endif
    status_check("midreset_status", 32'h0);
    spi_bits(8'h0f, 4, rx);
    status_check("ignored_tail_status", 32'h0);
    ss_high();
    bus_write(1'b1, 32'h10);
    frame1(8'h77, rx);
    sb.push_back(8'h77);
    check("post_reset_miso", {24'b0, rx}, 32'hff);
    status_check("post_reset_status", 32'h101 | IRQ_ST);
`ifdef SPI_SLAVE_MMIO_IRQ_EN
    check("irq_asserted", 32'(irq), 32'h1);
`endif
    drain(1);
    repeat (3) @(negedge clk);
`ifdef SPI_SLAVE_MMIO_IRQ_EN
    check("irq_cleared", 32'(irq), 32'h0);
`endif
    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    drain(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
